counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Round-robin scheduler that shares one `counter` instance (N-bit, enable/clear/wrap/max/at_max interface) among R requesters.
- Each requester asks for a delay of `delay[i]` ticks. The arbiter grants one requester at a time, programs the counter's max, runs it to at_max, then pulses that requester's `done`.
- Sits between the requesting FSMs and the shared counter; it is the only driver of the counter's control inputs.

Parameters:
- N, 4, counter width; must match the attached counter's N.
- R, 4, number of requesters (R >= 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- req  input  R  req[i]=1: requester i wants a delay; held high until done[i] or withdrawn.
- delay  input  R*N  packed; delay[i*N +: N] = ticks requested by requester i.
- grant  output  R  one-hot; grant[i]=1 while requester i owns the counter.
- done  output  R  one-cycle pulse on done[i] when requester i's delay completes.
- busy  output  1  1 in any state other than IDLE.
- cnt_enable  output  1  drives counter enable.
- cnt_clear  output  1  drives counter clear.
- cnt_wrap  output  1  drives counter wrap; constant 0 (hold at max).
- cnt_max  output  N  drives counter max; holds the latched delay of the granted requester.
- cnt_at_max  input  1  counter at_max.

Behaviour:
- FSM states: IDLE, RUN, DONE. Registered: state, idx (granted index), rr_ptr, max_q (N bits). All outputs decode from registered state only; there are no combinational paths from req, delay or cnt_at_max to any output.
- Reset: nrst=0 immediately forces state=IDLE, idx=0, rr_ptr=0, max_q=0. Outputs under reset: grant=0, done=0, busy=0, cnt_enable=0, cnt_clear=1, cnt_wrap=0, cnt_max=0. Reset mid-RUN abandons the transfer with no done pulse.
- IDLE outputs: cnt_clear=1, cnt_enable=0, grant=0. This keeps the counter parked at 0.
- IDLE transition:
  - If any req bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... mod R.
  - Latch idx and max_q = delay[idx] (sampled this cycle only; later changes ignored). Go to RUN.
  - If no req bit is set, stay in IDLE.
- RUN outputs: grant[idx]=1, cnt_enable=1, cnt_clear=0, busy=1, cnt_max=max_q.
- RUN transitions, in priority order:
  - req[idx]=0: abort. Go to IDLE, no done pulse, rr_ptr=idx+1 mod R.
  - cnt_at_max=1: go to DONE.
  - Otherwise stay in RUN.
- DONE outputs: done[idx]=1 for exactly one cycle, grant=0, cnt_enable=0, cnt_clear=1, busy=1.
- DONE transition: unconditionally go to IDLE; rr_ptr=idx+1 mod R.
- Latency:
  - The cycle req is sampled in IDLE is T.
  - RUN occupies T+1 .. T+1+delay, i.e. delay+1 cycles, because the counter counts 0..delay.
  - done is high in cycle T+delay+2.
  - delay=0 means at_max is true in the first RUN cycle, so done is high at T+2.
- Back-to-back grants have at least one IDLE cycle between them (DONE then IDLE). The next grant is issued in the IDLE cycle after DONE.
- Requests that arrive while busy are not lost; they are picked up in the next IDLE cycle, still in round-robin order.
- Requester constraint: requester i must deassert req[i] in the cycle done[i] is observed. Otherwise it is treated as a new request and may be re-granted after the others.
- cnt_max=max_q in every state; max_q retains its last value in IDLE and DONE.

Test Plan:
- Reset, then req=0001, delay0=5 sampled at T → grant=0001 over T+1..T+6, done=0001 only at T+7, busy low at T+8, counter count=0 at T+8.
- req=0001, delay0=0 → grant for 1 cycle (T+1), done pulse at T+2, cnt_max=0.
- req=1111 held, each delay=2, each requester drops its req on seeing its done → grant order 0001, 0010, 0100, 1000. Each done is 5 cycles apart (3 RUN + DONE + IDLE).
- req=0100 with delay=7 at T; req[2] dropped at T+3 → IDLE at T+4, no done, rr_ptr=3. Pending req[0] is then granted before req[2].
- nrst pulsed low mid-RUN, with no clk edge → grant=0 and cnt_clear=1 immediately. After release, arbitration restarts from requester 0 and no done is issued for the aborted transfer.
- delay[idx] changed during RUN → completion timing still uses the latched value; cnt_max stays constant throughout RUN.

Source files
------------

// File: rtl/counter_arbiter.sv
// ---------------------------------------------------------------------------
// counter_arbiter
//
// Round-robin scheduler that lends one shared N-bit counter to R requesters.
// A requester raises req[i] with its tick count on delay[i*N +: N]; the
// arbiter grants it the counter, programs cnt_max with the latched delay,
// runs the counter until cnt_at_max, then pulses done[i] for one cycle.
// The arbiter is the only driver of the counter's control inputs.
//
// Ports:
//   clk         rising-edge clock
//   nrst        asynchronous active-low reset
//   req[R]      request lines, held high until done[i] or withdrawn
//   delay[R*N]  packed per-requester tick counts
//   grant[R]    one-hot owner of the counter (RUN only)
//   done[R]     one-cycle completion pulse
//   busy        high whenever the arbiter is not idle
//   cnt_enable  counter enable
//   cnt_clear   counter clear (parks the counter at 0 outside RUN)
//   cnt_wrap    counter wrap, tied low so the counter holds at max
//   cnt_max     counter max, the latched delay of the granted requester
//   cnt_at_max  counter at_max flag
// ---------------------------------------------------------------------------
module counter_arbiter #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [R-1:0]     req,
    input  logic [R*N-1:0]   delay,
    output logic [R-1:0]     grant,
    output logic [R-1:0]     done,
    output logic             busy,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic             cnt_wrap,
    output logic [N-1:0]     cnt_max,
    input  logic             cnt_at_max
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rr_ptr;
    logic [N-1:0]    max_q;

    logic [IW-1:0]   idx_next;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [N-1:0]    delay_arr [R];

    // Index addition modulo R; works for R that is not a power of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input int off);
        logic [IW:0] sum;
        sum = {1'b0, base} + (IW+1)'(off);
        if (sum >= (IW+1)'(R))
            sum = sum - (IW+1)'(R);
        return sum[IW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < R; i++)
            delay_arr[i] = delay[i*N +: N];
    end

    assign idx_next = wrap_add(idx, 1);

    // Walk the offsets from the far end back towards rr_ptr so the last
    // assignment made is the set bit closest to rr_ptr.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = R - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr, i);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Controller. delay is sampled only in the IDLE cycle that issues the
    // grant; later changes on the delay bus never reach cnt_max. Both exits
    // from a transfer (abort and completion) advance rr_ptr past the owner.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            idx    <= '0;
            rr_ptr <= '0;
            max_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx   <= pick_idx;
                        max_q <= delay_arr[pick_idx];
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!req[idx]) begin
                        state  <= IDLE;
                        rr_ptr <= idx_next;
                    end else if (cnt_at_max) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    rr_ptr <= idx_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only from registered state, so nothing on req, delay
    // or cnt_at_max can ripple through to them in the same cycle.
    always_comb begin
        grant = '0;
        done  = '0;
        if (state == RUN)
            grant[idx] = 1'b1;
        if (state == DONE)
            done[idx] = 1'b1;
    end

    assign busy       = (state != IDLE);
    assign cnt_enable = (state == RUN);
    assign cnt_clear  = (state != RUN);
    assign cnt_wrap   = 1'b0;
    assign cnt_max    = max_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_arbiter
//
// Drives counter_arbiter with directed scenarios and then randomized
// requester traffic. A small counter model closes the loop on cnt_*.
// A transaction-level reference model predicts the owner and completion
// cycle of every grant and pushes it onto a scoreboard; a separate monitor
// pops an entry whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int R = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic             clk;
    logic             nrst;
    logic [R-1:0]     req;
    logic [R*N-1:0]   delay;
    logic [R-1:0]     grant;
    logic [R-1:0]     done;
    logic             busy;
    logic             cnt_enable;
    logic             cnt_clear;
    logic             cnt_wrap;
    logic [N-1:0]     cnt_max;
    logic             cnt_at_max;
    logic [N-1:0]     count;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   doneOrder[$];
    int   doneCycles[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int   mMode, mOwner, mPtr, mLat, mLeft;
    int   mSel, mCand;
    exp_t mon;
    int   dIdx;
    int   tStart;

    counter_arbiter #(.N(N), .R(R)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .delay      (delay),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .cnt_wrap   (cnt_wrap),
        .cnt_max    (cnt_max),
        .cnt_at_max (cnt_at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Shared counter: clear wins, counts up while enabled, holds at max.
    always @(posedge clk or negedge nrst) begin
        if (!nrst)
            count <= '0;
        else if (cnt_clear)
            count <= '0;
        else if (cnt_enable && count != cnt_max)
            count <= count + 1'b1;
        else if (cnt_enable && cnt_wrap)
            count <= '0;
    end
    assign cnt_at_max = (count == cnt_max);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic setDelay(input int i, input int d);
        logic [R*N-1:0] fieldMask;
        fieldMask = (R*N)'((1 << N) - 1) << (i * N);
        delay = (delay & ~fieldMask) | (((R*N)'(d) & (R*N)'((1 << N) - 1)) << (i * N));
    endtask

    task automatic applyStimulus(input int i, input int d);
        logic [R-1:0] bitMask;
        setDelay(i, d);
        bitMask = R'(1) << i;
        req = req | bitMask;
    endtask

    task automatic dropReq(input int i);
        logic [R-1:0] bitMask;
        bitMask = R'(1) << i;
        req = req & ~bitMask;
    endtask

    // Advance one cycle; every requester that sees its done withdraws.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < R; i++)
            if (((int'(done) >> i) & 1) == 1)
                dropReq(i);
    endtask

    task automatic resetDut();
        nrst = 1'b0;
        req  = '0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    function automatic int randDelay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return (1 << N) - 1;
        if (r == 1) return 0;
        return int'($urandom_range(1, 5));
    endfunction

    // Reference model: tracks who owns the counter and how many cycles the
    // transfer still needs; predicts each completion cycle at grant time.
    always @(negedge clk) begin
        if (!nrst) begin
            mMode  = M_IDLE;
            mOwner = 0;
            mPtr   = 0;
            mLat   = 0;
            mLeft  = 0;
            sb.delete();
            checkOutput("grant in reset", int'(grant), 0);
            checkOutput("clear in reset", int'(cnt_clear), 1);
        end else begin
            checkOutput("grant", int'(grant), (mMode == M_RUN) ? (1 << mOwner) : 0);
            checkOutput("busy", int'(busy), (mMode != M_IDLE) ? 1 : 0);
            checkOutput("cnt_enable", int'(cnt_enable), (mMode == M_RUN) ? 1 : 0);
            checkOutput("cnt_clear", int'(cnt_clear), (mMode != M_RUN) ? 1 : 0);
            checkOutput("cnt_wrap", int'(cnt_wrap), 0);
            checkOutput("cnt_max", int'(cnt_max), mLat);
            case (mMode)
                M_IDLE: begin
                    mSel = -1;
                    for (int k = 0; k < R; k++) begin
                        mCand = (mPtr + k) % R;
                        if (mSel < 0 && ((int'(req) >> mCand) & 1) == 1)
                            mSel = mCand;
                    end
                    if (mSel >= 0) begin
                        mOwner = mSel;
                        mLat   = (int'(delay) >> (mSel * N)) & ((1 << N) - 1);
                        mLeft  = mLat + 1;
                        sb.push_back('{idx: mSel, cyc: cyc + mLat + 2});
                        mMode  = M_RUN;
                    end
                end
                M_RUN: begin
                    if (((int'(req) >> mOwner) & 1) == 0) begin
                        if (sb.size() > 0)
                            sb.delete(sb.size() - 1);
                        mPtr  = (mOwner + 1) % R;
                        mMode = M_IDLE;
                    end else begin
                        mLeft = mLeft - 1;
                        if (mLeft == 0)
                            mMode = M_DONE;
                    end
                end
                default: begin
                    mPtr  = (mOwner + 1) % R;
                    mMode = M_IDLE;
                end
            endcase
        end
    end

    // Monitor: every done pulse must match the oldest predicted completion.
    always @(negedge clk) begin
        if (nrst) begin
            if (done != '0) begin
                dIdx = -1;
                for (int b = 0; b < R; b++)
                    if (dIdx < 0 && ((int'(done) >> b) & 1) == 1)
                        dIdx = b;
                doneOrder.push_back(dIdx);
                doneCycles.push_back(cyc);
                if (sb.size() == 0) begin
                    checkOutput("unexpected done", int'(done), 0);
                end else begin
                    mon = sb.pop_front();
                    checkOutput("done vector", int'(done), 1 << mon.idx);
                    checkOutput("done cycle", cyc, mon.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checkOutput("missing done", 0, 1 << sb[0].idx);
                sb.delete(0);
            end
        end
    end

    initial begin
        nrst  = 1'b0;
        req   = '0;
        delay = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset grant", int'(grant), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset cnt_enable", int'(cnt_enable), 0);
        checkOutput("reset cnt_clear", int'(cnt_clear), 1);
        checkOutput("reset cnt_max", int'(cnt_max), 0);
        nrst = 1'b1;
        stepCycle();

        // Single request, delay 5: done at T+7, counter parked afterwards.
        doneOrder.delete();
        doneCycles.delete();
        applyStimulus(0, 5);
        tStart = cyc;
        repeat (12) stepCycle();
        checkOutput("t1 done count", doneOrder.size(), 1);
        if (doneCycles.size() > 0)
            checkOutput("t1 done time", doneCycles[0], tStart + 7);
        checkOutput("t1 counter parked", int'(count), 0);

        // Zero delay: done two cycles after the sampling cycle.
        doneCycles.delete();
        applyStimulus(0, 0);
        tStart = cyc;
        repeat (6) stepCycle();
        checkOutput("t2 done count", doneCycles.size(), 1);
        if (doneCycles.size() > 0)
            checkOutput("t2 done time", doneCycles[0], tStart + 2);

        // All four requesting from a fresh pointer: grants rotate 0..3.
        resetDut();
        doneOrder.delete();
        doneCycles.delete();
        for (int i = 0; i < R; i++)
            applyStimulus(i, 2);
        repeat (30) stepCycle();
        checkOutput("t3 done count", doneOrder.size(), 4);
        for (int k = 0; k < doneOrder.size() && k < R; k++)
            checkOutput("t3 grant order", doneOrder[k], k);
        for (int k = 1; k < doneCycles.size(); k++)
            checkOutput("t3 done spacing", doneCycles[k] - doneCycles[k-1], 5);

        // Abort: requester 2 withdraws mid-run; pending 0 then wins over 2.
        doneOrder.delete();
        applyStimulus(2, 7);
        stepCycle();
        applyStimulus(0, 1);
        repeat (2) stepCycle();
        dropReq(2);
        stepCycle();
        checkOutput("t4 idle after abort", int'(busy), 0);
        applyStimulus(2, 1);
        repeat (15) stepCycle();
        checkOutput("t4 done count", doneOrder.size(), 2);
        if (doneOrder.size() == 2) begin
            checkOutput("t4 first after abort", doneOrder[0], 0);
            checkOutput("t4 second after abort", doneOrder[1], 2);
        end

        // Asynchronous reset in the middle of a transfer.
        doneOrder.delete();
        applyStimulus(1, 9);
        repeat (3) stepCycle();
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("async reset grant", int'(grant), 0);
        checkOutput("async reset clear", int'(cnt_clear), 1);
        checkOutput("async reset busy", int'(busy), 0);
        checkOutput("async reset cnt_max", int'(cnt_max), 0);
        req = '0;
        applyStimulus(0, 3);
        applyStimulus(1, 3);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (20) stepCycle();
        checkOutput("t5 done count", doneOrder.size(), 2);
        if (doneOrder.size() == 2) begin
            checkOutput("t5 restart at 0", doneOrder[0], 0);
            checkOutput("t5 then 1", doneOrder[1], 1);
        end

        // Delay bus changes during RUN must not affect the latched max.
        doneCycles.delete();
        applyStimulus(3, 4);
        tStart = cyc;
        repeat (2) stepCycle();
        setDelay(3, 15);
        repeat (10) stepCycle();
        checkOutput("t6 done count", doneCycles.size(), 1);
        if (doneCycles.size() > 0)
            checkOutput("t6 done time", doneCycles[0], tStart + 6);

        // Randomized traffic: new requests, withdrawals, delay-bus churn.
        for (int c = 0; c < 800; c++) begin
            stepCycle();
            for (int i = 0; i < R; i++) begin
                if (((int'(done) >> i) & 1) == 1) begin
                    // requester just completed; it stays quiet this cycle
                end else if (((int'(req) >> i) & 1) == 1) begin
                    if ($urandom_range(0, 39) == 0)
                        dropReq(i);
                    else if ($urandom_range(0, 7) == 0)
                        setDelay(i, randDelay());
                end else if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(i, randDelay());
                end
            end
        end

        for (int k = 0; k < 300 && !(req == '0 && busy == 1'b0); k++)
            stepCycle();
        checkOutput("drained", (req == '0 && busy == 1'b0) ? 1 : 0, 1);
        repeat (3) stepCycle();
        checkOutput("scoreboard empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
